// File: rtl/sobolflex_mc.sv
// Multi-channel, multi-context Sobol generator: one shared index per context drives
// NCH parallel dimensions whose direction vectors can be rewritten at run time.
module sobolflex_mc #(
   parameter  int BITWIDTH = 8,
   parameter  int NCH      = 2,
   parameter  int NCTX     = 2,
   localparam int CTXW     = (NCTX > 1) ? $clog2(NCTX) : 1,
   localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int KW       = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1
) (
   input  logic                    iClk,
   input  logic                    iRstN,
   input  logic                    iEn,
   input  logic                    iClr,
   input  logic [CTXW-1:0]         iCtx,
   input  logic                    iDvWe,
   input  logic [CHW-1:0]          iDvCh,
   input  logic [KW-1:0]           iDvIdx,
   input  logic [BITWIDTH-1:0]     iDvData,
   output logic [NCH*BITWIDTH-1:0] oRand,
   output logic [BITWIDTH-1:0]     oIdx,
   output logic                    oWrap
);

   // Position of the lowest zero bit of n; an all-ones n is handled separately as a wrap.
   function automatic logic [KW-1:0] lowZero(input logic [BITWIDTH-1:0] n);
      logic [KW-1:0] k;
      k = '0;
      for (int i = BITWIDTH - 1; i >= 0; i--) begin
         k = n[i] ? k : KW'(i);
      end
      return k;
   endfunction

   logic [BITWIDTH-1:0] dv_r   [NCH][BITWIDTH];
   logic [BITWIDTH-1:0] x_r    [NCTX][NCH];
   logic [BITWIDTH-1:0] idx_r  [NCTX];
   logic                wrap_r;

   logic                ctxValid_s;
   logic                dvValid_s;
   logic [CTXW-1:0]     ctxSel_s;
   logic [BITWIDTH-1:0] curIdx_s;
   logic                isWrap_s;
   logic [KW-1:0]       k_s;
   logic [BITWIDTH-1:0] stepX_s [NCH];
   logic [NCH*BITWIDTH-1:0] rand_s;

   assign ctxValid_s = ({1'b0, iCtx} < (CTXW + 1)'(NCTX));
   assign dvValid_s  = ({1'b0, iDvCh} < (CHW + 1)'(NCH)) && ({1'b0, iDvIdx} < (KW + 1)'(BITWIDTH));

   // Step datapath for the selected context; an invalid context is steered to 0 and never written.
   always_comb begin
      ctxSel_s = ctxValid_s ? iCtx : '0;
      curIdx_s = idx_r[ctxSel_s];
      isWrap_s = &curIdx_s;
      k_s      = lowZero(curIdx_s);
      for (int c = 0; c < NCH; c++) begin
         stepX_s[c] = isWrap_s ? '0 : (x_r[ctxSel_s][c] ^ dv_r[c][k_s]);
      end
   end

   // Output view of the selected context; reads 0 for an out-of-range context.
   always_comb begin
      rand_s = '0;
      for (int c = 0; c < NCH; c++) begin
         if (ctxValid_s) begin
            rand_s[c*BITWIDTH +: BITWIDTH] = x_r[ctxSel_s][c];
         end else begin
            rand_s[c*BITWIDTH +: BITWIDTH] = '0;
         end
      end
   end

   assign oRand = rand_s;
   assign oIdx  = ctxValid_s ? curIdx_s : '0;
   assign oWrap = wrap_r;

   // Per-context index and channel state, plus the one-cycle wrap pulse.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         for (int t = 0; t < NCTX; t++) begin
            idx_r[t] <= '0;
            for (int c = 0; c < NCH; c++) x_r[t][c] <= '0;
         end
         wrap_r <= 1'b0;
      end else if (iClr) begin
         for (int t = 0; t < NCTX; t++) begin
            idx_r[t] <= '0;
            for (int c = 0; c < NCH; c++) x_r[t][c] <= '0;
         end
         wrap_r <= 1'b0;
      end else if (iEn && ctxValid_s) begin
         idx_r[ctxSel_s] <= isWrap_s ? '0 : (curIdx_s + BITWIDTH'(1));
         for (int c = 0; c < NCH; c++) x_r[ctxSel_s][c] <= stepX_s[c];
         wrap_r <= isWrap_s;
      end else begin
         wrap_r <= 1'b0;
      end
   end

   // Direction-vector store; a step in the same cycle still sees the old vector.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < BITWIDTH; k++) begin
               dv_r[c][k] <= BITWIDTH'(1) << (BITWIDTH - 1 - k);
            end
         end
      end else if (iDvWe && dvValid_s) begin
         dv_r[iDvCh][iDvIdx] <= iDvData;
      end else begin
         dv_r <= dv_r;
      end
   end

endmodule

// File: tb/tb_sobolflex_mc.sv
// Self-checking bench for sobolflex_mc: directed scenarios plus randomized traffic
// compared against a Gray-code based Sobol reference model.
module tb_sobolflex_mc;
   localparam int BW   = 4;
   localparam int NCH  = 2;
   localparam int NCTX = 2;

   logic              iClk = 1'b0;
   logic              iRstN, iEn, iClr, iDvWe;
   logic [0:0]        iCtx, iDvCh;
   logic [1:0]        iDvIdx;
   logic [BW-1:0]     iDvData;
   logic [NCH*BW-1:0] oRand;
   logic [BW-1:0]     oIdx;
   logic              oWrap;

   int checks   = 0;
   int failures = 0;

   int mN [NCTX];
   int mX [NCTX][NCH];
   int mV [NCH][BW];
   bit mWrap;

   int defSeq [16] = '{0, 8, 12, 4, 6, 14, 10, 2, 3, 11, 15, 7, 5, 13, 9, 1};
   int altSeq [9]  = '{0, 8, 4, 12, 6, 14, 2, 10, 5};
   int altV   [4]  = '{8, 12, 10, 15};

   always #5 iClk = ~iClk;

   sobolflex_mc #(.BITWIDTH(BW), .NCH(NCH), .NCTX(NCTX)) dut (
      .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr), .iCtx(iCtx),
      .iDvWe(iDvWe), .iDvCh(iDvCh), .iDvIdx(iDvIdx), .iDvData(iDvData),
      .oRand(oRand), .oIdx(oIdx), .oWrap(oWrap)
   );

   function automatic int gray(int n);
      return n ^ (n >> 1);
   endfunction

   function automatic logic [31:0] chan(int c);
      return 32'(oRand[c*BW +: BW]);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int t = 0; t < NCTX; t++) begin
         mN[t] = 0;
         for (int c = 0; c < NCH; c++) mX[t][c] = 0;
      end
      for (int c = 0; c < NCH; c++)
         for (int k = 0; k < BW; k++) mV[c][k] = 1 << (BW - 1 - k);
      mWrap = 1'b0;
   endtask

   // Sobol step as the XOR of the vectors on the bits where the Gray code of n changes.
   task automatic modelEdge(bit en, bit clr, int ctx, bit we, int ch, int idx, int data);
      int d;
      if (clr) begin
         for (int t = 0; t < NCTX; t++) begin
            mN[t] = 0;
            for (int c = 0; c < NCH; c++) mX[t][c] = 0;
         end
         mWrap = 1'b0;
      end else if (en && ctx < NCTX) begin
         if (mN[ctx] == (1 << BW) - 1) begin
            mN[ctx] = 0;
            for (int c = 0; c < NCH; c++) mX[ctx][c] = 0;
            mWrap = 1'b1;
         end else begin
            d = gray(mN[ctx]) ^ gray(mN[ctx] + 1);
            for (int c = 0; c < NCH; c++)
               for (int j = 0; j < BW; j++)
                  if (((d >> j) & 1) == 1) mX[ctx][c] = mX[ctx][c] ^ mV[c][j];
            mN[ctx] = mN[ctx] + 1;
            mWrap = 1'b0;
         end
      end else begin
         mWrap = 1'b0;
      end
      if (we && ch < NCH && idx < BW) mV[ch][idx] = data;
   endtask

   task automatic checkOut();
      logic [31:0] expR;
      int ctx;
      ctx  = int'(iCtx);
      expR = '0;
      for (int c = 0; c < NCH; c++) expR = expR | (32'(mX[ctx][c]) << (c * BW));
      chk("rand", 32'(oRand), expR);
      chk("idx", 32'(oIdx), 32'(mN[ctx]));
      chk("wrap", 32'(oWrap), 32'(mWrap));
   endtask

   task automatic cyc(bit en, bit clr, int ctx, bit we = 1'b0, int ch = 0, int idx = 0, int data = 0);
      iEn = en; iClr = clr; iCtx = 1'(ctx);
      iDvWe = we; iDvCh = 1'(ch); iDvIdx = 2'(idx); iDvData = 4'(data);
      #1;
      checkOut();
      @(posedge iClk);
      modelEdge(en, clr, ctx, we, ch, idx, data);
      #1;
   endtask

   initial begin
      iRstN = 1'b0; iEn = 1'b0; iClr = 1'b0; iCtx = '0;
      iDvWe = 1'b0; iDvCh = '0; iDvIdx = '0; iDvData = '0;
      modelReset();
      #12;
      chk("reset_rand", 32'(oRand), 32'd0);
      chk("reset_idx", 32'(oIdx), 32'd0);
      chk("reset_wrap", 32'(oWrap), 32'd0);
      iRstN = 1'b1;
      @(posedge iClk);
      #1;

      // Default vectors: van der Corput in Gray order on both channels, then wrap.
      for (int i = 0; i < 16; i++) begin
         chk("def_ch0", chan(0), 32'(defSeq[i]));
         chk("def_ch1", chan(1), 32'(defSeq[i]));
         chk("def_idx", 32'(oIdx), 32'(i));
         cyc(1'b1, 1'b0, 0);
      end
      chk("wrap_rand", 32'(oRand), 32'd0);
      chk("wrap_idx", 32'(oIdx), 32'd0);
      chk("wrap_pulse", 32'(oWrap), 32'd1);
      cyc(1'b0, 1'b0, 0);
      chk("wrap_drop", 32'(oWrap), 32'd0);

      // Rewritten channel-1 vectors.
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 0, 1'b1, 1, k, altV[k]);
      for (int i = 0; i < 9; i++) begin
         chk("alt_ch1", chan(1), 32'(altSeq[i]));
         chk("alt_ch0", chan(0), 32'(defSeq[i]));
         cyc(1'b1, 1'b0, 0);
      end

      // Context isolation.
      cyc(1'b0, 1'b1, 0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 0);
      chk("iso_ctx0", chan(0), 32'd4);
      cyc(1'b1, 1'b0, 1);
      chk("iso_ctx1_ch0", chan(0), 32'd8);
      chk("iso_ctx1_idx", 32'(oIdx), 32'd1);
      iCtx = 1'b0;
      #1;
      chk("iso_back_ch0", chan(0), 32'd4);
      chk("iso_back_idx", 32'(oIdx), 32'd3);

      // Clear wins over step; vectors survive.
      cyc(1'b1, 1'b1, 0);
      chk("clr_rand0", 32'(oRand), 32'd0);
      chk("clr_idx0", 32'(oIdx), 32'd0);
      chk("clr_wrap", 32'(oWrap), 32'd0);
      iCtx = 1'b1;
      #1;
      chk("clr_rand1", 32'(oRand), 32'd0);
      chk("clr_idx1", 32'(oIdx), 32'd0);
      cyc(1'b1, 1'b0, 0);
      chk("clr_next", chan(0), 32'd8);

      // Vector write concurrent with a step that uses it.
      cyc(1'b0, 1'b1, 0);
      cyc(1'b1, 1'b0, 0, 1'b1, 0, 0, 1);
      chk("wr_old", chan(0), 32'd8);
      cyc(1'b0, 1'b1, 0);
      cyc(1'b1, 1'b0, 0);
      chk("wr_new", chan(0), 32'd1);

      // Randomized traffic against the model.
      repeat (400) begin
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 1),
             $urandom_range(0, 7) == 0, $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 15));
      end

      // Asynchronous reset during a step restores default vectors.
      cyc(1'b0, 1'b0, 0, 1'b1, 1, 0, 5);
      iEn = 1'b1; iCtx = 1'b0; iDvWe = 1'b0;
      @(posedge iClk);
      #2;
      iRstN = 1'b0;
      #1;
      modelReset();
      chk("arst_rand", 32'(oRand), 32'd0);
      chk("arst_idx", 32'(oIdx), 32'd0);
      chk("arst_wrap", 32'(oWrap), 32'd0);
      iEn = 1'b0;
      @(negedge iClk);
      iRstN = 1'b1;
      @(posedge iClk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("arst_ch1", chan(1), 32'(defSeq[i]));
         cyc(1'b1, 1'b0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
